timer_counter: RTL and testbench
================================

# timer_counter

- Memory-mapped 32-bit down-counting timer; one instance per timer slot behind the system bridge.
- Consumes the bridge's word address, write enable and write data; returns read data.
- Raises a level interrupt that the bridge packs into `HWInt` for CP0.
- Supports one-shot (mode 0) and auto-reload (mode 1) operation. Its behaviour is what makes timer interrupts in exception-handler tests deterministic.

## Interface
- No parameters; register map fixed.
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- Addr  input  30  word address (byte address [31:2]); only Addr[1:0] (byte offset bits 3:2) decoded.
- WE  input  1  write strobe, already qualified by the bridge for slot, `sw` and no pending interrupt.
- Din  input  32  write data.
- Dout  output  32  combinational read data for Addr.
- IRQ  output  1  interrupt request, level.

## Operation
- Register map by Addr[1:0]:
  - 0 CTRL, R/W: bit0 En, bits2:1 Mode, bit3 IM; other bits read 0.
  - 1 PRESET, R/W, 32 bits.
  - 2 COUNT, read-only; writes ignored.
  - 3 see Configuration.
- FSM states are IDLE, LOAD, CNT, INT.
  - IDLE: En=1 -> LOAD; otherwise stay. COUNT holds.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT: En=0 -> IDLE. COUNT==0 -> INT. Otherwise COUNT <= COUNT-1.
  - INT, Mode 1: -> LOAD.
  - INT, any other Mode (0, 2, 3 all one-shot): En <= 0; -> IDLE.
- irq_flag:
  - Set on entry to INT.
  - Mode 1: cleared on exit from INT (one-cycle pulse).
  - One-shot: held until any write to CTRL or PRESET.
- IRQ = irq_flag & IM.
- A CTRL write forces the next state to IDLE, and it overrides any concurrent FSM transition. The FSM restarts through LOAD if the written En=1.
- A PRESET write during CNT does not change COUNT; it takes effect at the next LOAD.
- Arithmetic:
  - COUNT is unsigned 32-bit and never decrements below 0 (no wrap).
  - PRESET=0xFFFFFFFF is legal.
- Disable mid-count (CTRL write with En=0): COUNT frozen at its current value; irq_flag cleared.

## Timing
- Reset (async, reset=0): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0.
  - Outputs after reset: IRQ=0, Dout reflects zeroed registers.
- Register writes commit on the edge where WE=1; readable via Dout in the following cycle.
- Writing CTRL with En=1 at edge E0, PRESET=N already programmed:
  - LOAD at E1.
  - COUNT=N after E2.
  - COUNT=0 after E(N+2).
  - INT and IRQ high after E(N+3).
- Mode 1 period: INT recurs every N+3 cycles. IRQ is high for exactly one cycle per period.
- IRQ is registered only: no combinational path from Din or WE to IRQ.
- Reset mid-count: all state cleared immediately; IRQ drops asynchronously.

## Configuration
- TC_PRESCALE_EN defined:
  - Offset 3 is PRESCALE, R/W, bits 7:0; other bits read 0; reset value 0.
  - In CNT, COUNT decrements, and the COUNT==0 -> INT check is taken, only once every PRESCALE+1 cycles.
  - The internal prescale counter clears in LOAD and on any CTRL write.
  - Timing becomes: INT after (N+1)*(PRESCALE+1)+2 cycles from the CTRL-write edge. PRESCALE=0 gives the same timing as the undefined case.
- TC_PRESCALE_EN undefined:
  - Offset 3 reads 0 and writes are ignored.
  - COUNT decrements every CNT cycle.

## Test plan
- Reset: reset=0 for 2 cycles then 1 -> Dout reads 0 at all offsets; IRQ=0.
- One-shot:
  - Stimulus: PRESET=5, then CTRL=0x9 (En=1, Mode0, IM=1).
  - Required: IRQ rises 8 cycles after the CTRL write, stays high, and CTRL reads 0x8.
  - Then PRESET write -> IRQ low next cycle.
- Auto-reload:
  - Stimulus: PRESET=2, CTRL=0xB.
  - Required: IRQ one-cycle pulses with 5-cycle spacing for at least 4 periods; COUNT sequence 2,1,0 repeats.
- Mask and disable:
  - CTRL=0x1 with PRESET=3 -> IRQ never asserts, CTRL reads 0 after expiry.
  - Mid-count CTRL=0x0 with PRESET=100 -> COUNT freezes at its current value.
- Collision: CTRL write on the same edge as CNT->INT -> write wins; state IDLE, no IRQ.
- TC_PRESCALE_EN defined: PRESCALE=3, PRESET=2, CTRL=0x9 -> IRQ after 14 cycles; offset 3 reads 0x3.

Source files
------------

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped 32-bit down-counting timer, one-shot or auto-reload, level IRQ.
// Define TC_PRESCALE_EN to add the 8-bit PRESCALE register at offset 3.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic [1:0]  dbgState
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] CNT  = 2'd2;
    localparam logic [1:0] INT  = 2'd3;

    logic [1:0]  state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irqFlag;
    logic        wrCtrl;
    logic        wrPreset;
    logic        tick;
    logic        enterInt;
    logic        autoReload;
    logic        unusedAddr;

    // Only the byte-offset bits select a register; the bridge has already decoded the slot.
    assign unusedAddr = ^Addr[29:2];
    assign wrCtrl     = WE && (Addr[1:0] == 2'd0);
    assign wrPreset   = WE && (Addr[1:0] == 2'd1);
    assign autoReload = (ctrl[2:1] == 2'd1);

`ifdef TC_PRESCALE_EN
    logic [7:0] prescale;
    logic [7:0] preCnt;

    // >= keeps the divider from running away if PRESCALE is lowered mid-count.
    assign tick = (preCnt >= prescale);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale <= '0;
            preCnt   <= '0;
        end else begin
            if (WE && (Addr[1:0] == 2'd3)) prescale <= Din[7:0];
            if (wrCtrl || (state == LOAD)) preCnt <= '0;
            else if ((state == CNT) && ctrl[0]) preCnt <= tick ? 8'd0 : preCnt + 8'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign enterInt = (state == CNT) && ctrl[0] && tick && (count == 32'd0) && !wrCtrl;

    // A CTRL write takes precedence over whatever the FSM would have done this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            ctrl   <= '0;
            preset <= '0;
            count  <= '0;
        end else begin
            if (wrPreset) preset <= Din;
            if (wrCtrl) begin
                ctrl  <= Din[3:0];
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (ctrl[0]) state <= LOAD;
                    LOAD: begin
                        count <= preset;
                        state <= CNT;
                    end
                    CNT: begin
                        if (!ctrl[0]) state <= IDLE;
                        else if (tick) begin
                            if (count == 32'd0) state <= INT;
                            else count <= count - 32'd1;
                        end
                    end
                    INT: begin
                        if (autoReload) state <= LOAD;
                        else begin
                            ctrl[0] <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irqFlag <= 1'b0;
        else if (wrCtrl) irqFlag <= 1'b0;
        else if (enterInt) irqFlag <= 1'b1;
        else if ((state == INT) && autoReload) irqFlag <= 1'b0;
        else if (wrPreset) irqFlag <= 1'b0;
    end

    assign IRQ      = irqFlag & ctrl[3];
    assign dbgState = state;

    always_comb begin
        Dout = '0;
        case (Addr[1:0])
            2'd0: Dout = {28'd0, ctrl};
            2'd1: Dout = preset;
            2'd2: Dout = count;
            default: begin
`ifdef TC_PRESCALE_EN
                Dout = {24'd0, prescale};
`else
                Dout = '0;
`endif
            end
        endcase
    end
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed scoreboard bench for timer_counter.
// Handshake: step() drives inputs 1 time unit after a rising edge and queues its expectations; the monitor consumes them on the falling edge.
module tb_timer_counter;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] CNT  = 2'd2;
    localparam logic [1:0] INT  = 2'd3;

    logic        clk;
    logic        reset;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;
    logic [1:0]  dbgState;

    logic [31:0] expQ[$];
    int          kindQ[$];
    string       nameQ[$];
    int          nChk;
    int          passCnt;
    int          totalCnt;

    timer_counter dut (
        .clk(clk),
        .reset(reset),
        .Addr(Addr),
        .WE(WE),
        .Din(Din),
        .Dout(Dout),
        .IRQ(IRQ),
        .dbgState(dbgState)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        for (int i = 0; i < nChk; i++) begin
            if (expQ.size() == 0) begin
                check("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                int          mKind;
                logic [31:0] mExp;
                logic [31:0] mAct;
                string       mName;
                mKind = kindQ.pop_front();
                mExp  = expQ.pop_front();
                mName = nameQ.pop_front();
                case (mKind)
                    0:       mAct = Dout;
                    1:       mAct = {31'd0, IRQ};
                    default: mAct = {30'd0, dbgState};
                endcase
                check(mName, mAct, mExp);
            end
        end
    end

    // driver tasks
    task automatic step(input logic we, input logic [1:0] a, input logic [31:0] d,
                        input bit cD, input logic [31:0] eD,
                        input bit cI, input logic eI,
                        input bit cS, input logic [1:0] eS, input string nm);
        Addr = {28'd0, a};
        WE   = we;
        Din  = d;
        nChk = 0;
        if (cD) begin
            kindQ.push_back(0); expQ.push_back(eD); nameQ.push_back({nm, "_dout"}); nChk++;
        end
        if (cI) begin
            kindQ.push_back(1); expQ.push_back({31'd0, eI}); nameQ.push_back({nm, "_irq"}); nChk++;
        end
        if (cS) begin
            kindQ.push_back(2); expQ.push_back({30'd0, eS}); nameQ.push_back({nm, "_state"}); nChk++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step(1'b1, a, d, 0, '0, 0, 1'b0, 0, IDLE, "wr");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd2, '0, 0, '0, 0, 1'b0, 0, IDLE, "idle");
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        step(1'b0, a, '0, 1, e, 0, 1'b0, 0, IDLE, nm);
    endtask

    task automatic rdIrq(input logic [1:0] a, input logic [31:0] e, input logic eI, input string nm);
        step(1'b0, a, '0, 1, e, 1, eI, 0, IDLE, nm);
    endtask

    task automatic full(input logic [1:0] a, input logic [31:0] e, input logic eI,
                        input logic [1:0] eS, input string nm);
        step(1'b0, a, '0, 1, e, 1, eI, 1, eS, nm);
    endtask

    initial begin
        passCnt  = 0;
        totalCnt = 0;
        nChk     = 0;
        reset    = 1'b0;
        WE       = 1'b0;
        Addr     = '0;
        Din      = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // reset state
        full(2'd0, 32'd0, 1'b0, IDLE, "rst_ctrl");
        rd(2'd1, 32'd0, "rst_preset");
        rd(2'd2, 32'd0, "rst_count");
        rd(2'd3, 32'd0, "rst_off3");

        // one-shot: PRESET=5, CTRL=0x9, IRQ visible 9 steps after the write step
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        full(2'd0, 32'h9, 1'b0, IDLE, "os_s1");
        full(2'd2, 32'd0, 1'b0, LOAD, "os_s2");
        for (int k = 3; k <= 8; k++) rdIrq(2'd2, 32'(5 - (k - 3)), 1'b0, $sformatf("os_cnt%0d", k));
        full(2'd0, 32'h9, 1'b1, INT, "os_int");
        full(2'd0, 32'h8, 1'b1, IDLE, "os_done");
        rdIrq(2'd2, 32'd0, 1'b1, "os_hold");
        step(1'b1, 2'd1, 32'd7, 0, '0, 1, 1'b1, 0, IDLE, "os_prewr");
        rdIrq(2'd1, 32'd7, 1'b0, "os_clr");

        // auto-reload: PRESET=2, CTRL=0xB, period 5
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        rdIrq(2'd2, 32'd0, 1'b0, "ar_s1");
        rdIrq(2'd2, 32'd0, 1'b0, "ar_s2");
        for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < 5; j++) begin
                full(2'd2, (j < 3) ? 32'(2 - j) : 32'd0, (j == 3),
                     (j < 3) ? CNT : ((j == 3) ? INT : LOAD), $sformatf("ar_p%0d_j%0d", p, j));
            end
        end

        // collision: CTRL write lands on the CNT->INT edge
        full(2'd2, 32'd2, 1'b0, CNT, "col_c2");
        full(2'd2, 32'd1, 1'b0, CNT, "col_c1");
        step(1'b1, 2'd0, 32'h8, 1, 32'hB, 1, 1'b0, 1, CNT, "col_wr");
        full(2'd0, 32'h8, 1'b0, IDLE, "col_a1");
        full(2'd2, 32'd0, 1'b0, IDLE, "col_a2");
        full(2'd2, 32'd0, 1'b0, IDLE, "col_a3");

        // masked one-shot: IRQ stays low, En clears after expiry
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 10; k++) rdIrq(2'd0, (k <= 7) ? 32'h1 : 32'h0, 1'b0, $sformatf("mask_s%0d", k));
        full(2'd0, 32'd0, 1'b0, IDLE, "mask_end");

        // disable mid-count freezes COUNT
        wr(2'd1, 32'd100);
        wr(2'd0, 32'h9);
        idle(2);
        for (int k = 3; k <= 9; k++) rd(2'd2, 32'(100 - (k - 3)), $sformatf("dis_cnt%0d", k));
        step(1'b1, 2'd0, 32'h8, 0, '0, 1, 1'b0, 1, CNT, "dis_wr");
        for (int k = 11; k <= 13; k++) full(2'd2, 32'd93, 1'b0, IDLE, $sformatf("dis_frz%0d", k));

        // full-scale PRESET
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, 32'hFFFF_FFFF, "max_preset");
        wr(2'd0, 32'h1);
        idle(2);
        rd(2'd2, 32'hFFFF_FFFF, "max_c0");
        rd(2'd2, 32'hFFFF_FFFE, "max_c1");
        wr(2'd0, 32'h0);
        rd(2'd2, 32'hFFFF_FFFD, "max_frz");

`ifdef TC_PRESCALE_EN
        wr(2'd3, 32'h3);
        rd(2'd3, 32'h3, "pre_rd");
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 14; k++) rdIrq(2'd3, 32'h3, 1'b0, $sformatf("pre_s%0d", k));
        rdIrq(2'd3, 32'h3, 1'b1, "pre_int");
        wr(2'd3, 32'h0);
        wr(2'd0, 32'h0);
        rdIrq(2'd0, 32'h0, 1'b0, "pre_clr");
`else
        wr(2'd3, 32'h55);
        rd(2'd3, 32'h0, "off3_rd");
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 5; k++) rdIrq(2'd3, 32'h0, 1'b0, $sformatf("off3_s%0d", k));
        rdIrq(2'd3, 32'h0, 1'b1, "off3_int");
        wr(2'd0, 32'h0);
        rdIrq(2'd0, 32'h0, 1'b0, "off3_clr");
`endif

        // asynchronous reset while IRQ is high
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        idle(4);
        rdIrq(2'd0, 32'h9, 1'b1, "ar_pre");
        nChk = 0;
        Addr = '0;
        #2;
        reset = 1'b0;
        #1;
        check("async_irq", {31'd0, IRQ}, 32'd0);
        check("async_ctrl", Dout, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        full(2'd1, 32'd0, 1'b0, IDLE, "post_rst");

        nChk = 0;
        @(negedge clk);
        if (expQ.size() != 0) check("scoreboard_leftover", expQ.size(), 32'd0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
